// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: sequencer state
// encodings, frame length and default sizing constants.
package uart_tx_queue_pkg;

    typedef enum logic [1:0] {
        TXQ_IDLE = 2'd0,
        TXQ_ARM  = 2'd1,
        TXQ_SEND = 2'd2
    } txqState_t;

    // start + 8 data + stop
    localparam int TXQ_FRAME_BITS    = 10;
    // 16 clocks per bit keeps us aligned with a 16x oversampling receiver
    localparam int TXQ_DEFAULT_DIV   = 16;
    localparam int TXQ_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/uart_tx_queue_fifo.sv
// txq_fifo: byte queue feeding the transmitter. Holds storage, pointers,
// occupancy and the write-accept rule. A write at full is still accepted
// when the head is popped in the same cycle.
module txq_fifo
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH  = TXQ_DEFAULT_DEPTH,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [7:0]        wrData,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic [7:0]        dataOut
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [ADDR_W:0]   count;
    logic              doPop;
    logic              doPush;

    // Occupancy flags and the accept rule; a pop on an empty queue is ignored.
    always_comb begin
        full    = (count == (ADDR_W+1)'(DEPTH));
        empty   = (count == (ADDR_W+1)'(0));
        doPop   = pop & ~empty;
        doPush  = wrEn & (~full | doPop);
        level   = count;
        dataOut = mem[rdPtr];
    end

    // Pointer and occupancy state; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= {ADDR_W{1'b0}};
            rdPtr <= {ADDR_W{1'b0}};
            count <= {(ADDR_W+1){1'b0}};
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + ADDR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + ADDR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: contents are only meaningful while counted.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue and sequencer in front of the UART transmitter.
// Generates the free-running bit-rate enable and the shift/load strobe, and
// hands one queued byte per frame to the transmitter.
// Optional feature macro: TXQ_OVERFLOW_EN adds a sticky 'overflow' output
// flagging writes rejected at full; without it such writes are dropped.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH  = TXQ_DEFAULT_DEPTH,
    parameter int ADDR_W = 2,
    parameter int DIV    = TXQ_DEFAULT_DIV
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [7:0]        wrData,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    input  logic              txEmpty,
    output logic              enable,
    output logic              shiftLoad,
    output logic [7:0]        dataOut
`ifdef TXQ_OVERFLOW_EN
    ,output logic             overflow
`endif
);

    localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] divCnt;
    txqState_t        state;
    txqState_t        nextState;
    logic             pop;

    txq_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) fifo (
        .clock   (clock),
        .reset   (reset),
        .wrEn    (wrEn),
        .wrData  (wrData),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .dataOut (dataOut)
    );

    // Free-running bit-rate divider; never stalled by the sequencer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divCnt <= {DIV_W{1'b0}};
        end else if (divCnt == DIV_LAST) begin
            divCnt <= {DIV_W{1'b0}};
        end else begin
            divCnt <= divCnt + DIV_W'(1);
        end
    end

    assign enable = (divCnt == DIV_LAST);

    // Sequencer state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= TXQ_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Sequencer next state, load strobe and pop. The pop coincides with the
    // enable on which the transmitter loads the head byte; the transmitter
    // drops txEmpty the following cycle, so SEND cannot exit early.
    always_comb begin
        nextState = state;
        shiftLoad = 1'b1;
        pop       = 1'b0;
        case (state)
            TXQ_IDLE: begin
                if (!empty && txEmpty) begin
                    nextState = TXQ_ARM;
                end else begin
                    nextState = TXQ_IDLE;
                end
            end
            TXQ_ARM: begin
                shiftLoad = 1'b0;
                if (enable) begin
                    pop       = 1'b1;
                    nextState = TXQ_SEND;
                end else begin
                    nextState = TXQ_ARM;
                end
            end
            TXQ_SEND: begin
                if (txEmpty) begin
                    nextState = TXQ_IDLE;
                end else begin
                    nextState = TXQ_SEND;
                end
            end
            default: begin
                nextState = TXQ_IDLE;
            end
        endcase
    end

`ifdef TXQ_OVERFLOW_EN
    logic overflowReg;

    // Sticky record of any write refused because the queue was full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflowReg <= 1'b0;
        end else if (wrEn && full && !pop) begin
            overflowReg <= 1'b1;
        end else begin
            overflowReg <= overflowReg;
        end
    end

    assign overflow = overflowReg;
`endif

endmodule
